coe_loader: RTL and testbench



---
 rtl/coe_loader_if.sv | 26 ++
 rtl/coe_loader.sv | 116 +++++++++++
 tb/tb_coe_loader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/coe_loader_if.sv
// Byte-stream input and frame-buffer write port of the picture loader.
// Pure wiring; no latency of its own.
// No back-pressure: in_ready is high in every state except reset.
interface coe_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_en;
  logic        busy;
  logic        frame_done;
  logic        err;

  // Byte source / status observer side
  modport master (
    output in_data, in_valid,
    input  in_ready, wr_addr, wr_data, wr_en, busy, frame_done, err
  );

  // Loader side
  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_addr, wr_data, wr_en, busy, frame_done, err
  );
endinterface

// File: rtl/coe_loader.sv
// Writes a header-synced byte stream into the image RAM as sequential RGB444 pixels.
// Latency: the RAM write strobe fires one cycle after the low (G/B) byte is accepted.
// Never back-pressures; a mid-frame stall longer than TIMEOUT_CYCLES aborts the frame.
module coe_loader #(
  parameter int         PICTURE_WIDTH  = 270,
  parameter int         PICTURE_HEIGHT = 384,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         rst_n,
  coe_loader_if.slave  bus
);

  localparam int          PIXEL_COUNT = PICTURE_WIDTH * PICTURE_HEIGHT;
  localparam logic [16:0] LAST_PIX    = 17'(PIXEL_COUNT - 1);
  localparam logic [23:0] LAST_IDLE   = 24'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HI   = 2'd1,
    S_LO   = 2'd2
  } state_t;

  state_t      r_state;
  logic [16:0] r_pix;
  logic [23:0] r_idle;
  logic [3:0]  r_red;
  logic        r_in_ready;
  logic [16:0] r_wr_addr;
  logic [11:0] r_wr_data;
  logic        r_wr_en;
  logic        r_busy;
  logic        r_frame_done;
  logic        r_err;

  logic w_acc;

  assign w_acc = bus.in_valid & r_in_ready;

  // Header sync, byte-pair packing, pixel addressing and stall timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pix        <= '0;
      r_idle       <= '0;
      r_red        <= '0;
      r_in_ready   <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_wr_en      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_in_ready   <= 1'b1;
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
      // busy stays up through the frame_done cycle and drops right after
      if (r_frame_done) r_busy <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_idle <= '0;
          if (w_acc && bus.in_data == SYNC_BYTE) begin
            r_state <= S_HI;
            r_busy  <= 1'b1;
          end
        end

        S_HI, S_LO: begin
          if (w_acc) begin
            // An accept on the expiry cycle still counts: no abort
            r_idle <= '0;
            if (r_state == S_HI) begin
              r_red   <= bus.in_data[3:0];
              r_state <= S_LO;
            end else begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_pix;
              r_wr_data <= {r_red, bus.in_data};
              if (r_pix == LAST_PIX) begin
                r_pix        <= '0;
                r_frame_done <= 1'b1;
                r_state      <= S_IDLE;
              end else begin
                r_pix   <= r_pix + 17'd1;
                r_state <= S_HI;
              end
            end
          end else if (r_idle == LAST_IDLE) begin
            r_state <= S_IDLE;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_pix   <= '0;
            r_idle  <= '0;
          end else begin
            r_idle <= r_idle + 24'd1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.wr_en      = r_wr_en;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_coe_loader.sv
// Directed bench for coe_loader with a 4x2 picture and a 5-cycle stall timeout.
// Writes, frame_done and err pulses are logged on the falling edge with their cycle number.
// Inputs change 1 ns after the rising edge; outputs are read 1 ns after it or on the falling edge.
module tb_coe_loader;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   acc_cyc;
  int   fd_cnt;
  int   err_cnt;
  int   err_cyc;
  int   c0;

  typedef struct {
    logic [16:0] a;
    logic [11:0] d;
    int          c;
    logic        fd;
  } wr_t;

  wr_t wq[$];

  coe_loader_if bus ();

  coe_loader #(
    .PICTURE_WIDTH  (4),
    .PICTURE_HEIGHT (2),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every write and status pulse with the cycle it appeared in
  always @(negedge clk) begin
    if (bus.wr_en) wq.push_back('{a: bus.wr_addr, d: bus.wr_data, c: cyc, fd: bus.frame_done});
    if (bus.frame_done) fd_cnt++;
    if (bus.err) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [7:0] hi_t [8] = '{8'h31, 8'h42, 8'hF3, 8'hA5, 8'h07, 8'h1E, 8'h9C, 8'h6D};
  logic [7:0] lo_t [8] = '{8'h00, 8'hFF, 8'hA5, 8'h5A, 8'h12, 8'h34, 8'h56, 8'h78};
  int         acc_lo [8];
  logic [7:0] junk [6] = '{8'h0F, 8'hFF, 8'h01, 8'h02, 8'h8C, 8'h33};

  initial begin
    cyc = 0; checks = 0; errors = 0; fd_cnt = 0; err_cnt = 0; err_cyc = -1;
    rst_n = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);

    // Junk before header is discarded; header raises busy; one pixel follows
    send(8'h00);
    send(8'h37);
    chk("junk_busy", 32'(bus.busy), 32'd0);
    chk("junk_no_write", 32'(wq.size()), 32'd0);
    send(8'hA5);
    chk("hdr_busy", 32'(bus.busy), 32'd1);
    chk("hdr_no_wr", 32'(bus.wr_en), 32'd0);
    send(8'h0F);
    chk("hi_no_wr", 32'(bus.wr_en), 32'd0);
    send(8'h8C);
    c0 = acc_cyc;
    bus.in_valid = 1'b0;
    chk("p0_wr_en", 32'(bus.wr_en), 32'd1);
    chk("p0_addr", 32'(bus.wr_addr), 32'd0);
    chk("p0_data", 32'(bus.wr_data), 32'hF8C);
    idle(1);
    chk("p0_wr_en_drop", 32'(bus.wr_en), 32'd0);
    chk("p0_addr_hold", 32'(bus.wr_addr), 32'd0);
    chk("p0_data_hold", 32'(bus.wr_data), 32'hF8C);
    // Left stalled mid-frame: aborts 5 cycles after the last accept
    idle(6);
    chk("t1_err_cnt", 32'(err_cnt), 32'd1);
    chk("t1_err_cycle", 32'(err_cyc), 32'(c0 + 5));
    chk("t1_busy", 32'(bus.busy), 32'd0);
    chk("t1_writes", 32'(wq.size()), 32'd1);

    // Full 8-pixel frame with gaps; SYNC_BYTE inside a frame is plain data
    wq.delete(); fd_cnt = 0; err_cnt = 0;
    send(8'hA5);
    for (int i = 0; i < 8; i++) begin
      send(hi_t[i]);
      if (i % 2 == 0) idle(1);
      send(lo_t[i]);
      acc_lo[i] = acc_cyc;
      if (i == 7) begin
        chk("f_last_done", 32'(bus.frame_done), 32'd1);
        chk("f_last_wr_en", 32'(bus.wr_en), 32'd1);
        chk("f_last_addr", 32'(bus.wr_addr), 32'd7);
        chk("f_last_busy", 32'(bus.busy), 32'd1);
      end else if (i % 2 == 1) begin
        idle(2);
      end
    end
    idle(1);
    chk("f_busy_after", 32'(bus.busy), 32'd0);
    chk("f_done_after", 32'(bus.frame_done), 32'd0);
    chk("f_write_count", 32'(wq.size()), 32'd8);
    for (int i = 0; i < 8 && i < wq.size(); i++) begin
      chk($sformatf("f_addr%0d", i), 32'(wq[i].a), 32'(i));
      chk($sformatf("f_data%0d", i), 32'(wq[i].d), 32'({hi_t[i][3:0], lo_t[i]}));
      chk($sformatf("f_cyc%0d", i), 32'(wq[i].c), 32'(acc_lo[i]));
      chk($sformatf("f_fd%0d", i), 32'(wq[i].fd), (i == 7) ? 32'd1 : 32'd0);
    end
    chk("f_done_pulses", 32'(fd_cnt), 32'd1);
    chk("f_no_err", 32'(err_cnt), 32'd0);
    send(8'hA5);
    send(8'h01);
    send(8'h23);
    bus.in_valid = 1'b0;
    chk("f2_addr", 32'(bus.wr_addr), 32'd0);
    chk("f2_data", 32'(bus.wr_data), 32'h123);
    chk("f2_wr_en", 32'(bus.wr_en), 32'd1);
    idle(7);

    // Timeout after header plus one byte
    err_cnt = 0;
    send(8'hA5);
    send(8'h03);
    c0 = acc_cyc;
    idle(4);
    chk("to_err_early", 32'(bus.err), 32'd0);
    chk("to_busy_early", 32'(bus.busy), 32'd1);
    idle(1);
    chk("to_err", 32'(bus.err), 32'd1);
    chk("to_err_cycle", 32'(cyc), 32'(c0 + 5));
    chk("to_busy", 32'(bus.busy), 32'd0);
    idle(1);
    chk("to_err_one_cycle", 32'(bus.err), 32'd0);
    chk("to_err_cnt", 32'(err_cnt), 32'd1);
    send(8'hA5);
    send(8'h0B);
    send(8'hCD);
    bus.in_valid = 1'b0;
    chk("to_new_wr_en", 32'(bus.wr_en), 32'd1);
    chk("to_new_addr", 32'(bus.wr_addr), 32'd0);
    chk("to_new_data", 32'(bus.wr_data), 32'hBCD);
    idle(7);

    // Accept on the 5th idle cycle beats the timeout
    err_cnt = 0;
    send(8'hA5);
    send(8'h04);
    idle(4);
    send(8'h56);
    chk("race_wr_en", 32'(bus.wr_en), 32'd1);
    chk("race_err", 32'(bus.err), 32'd0);
    chk("race_addr", 32'(bus.wr_addr), 32'd0);
    chk("race_data", 32'(bus.wr_data), 32'h456);
    send(8'h07);
    send(8'h89);
    chk("race_p1_addr", 32'(bus.wr_addr), 32'd1);
    chk("race_p1_data", 32'(bus.wr_data), 32'h789);
    send(8'h0A);
    send(8'hBC);
    bus.in_valid = 1'b0;
    chk("race_p2_addr", 32'(bus.wr_addr), 32'd2);
    chk("race_p2_busy", 32'(bus.busy), 32'd1);
    chk("race_err_cnt", 32'(err_cnt), 32'd0);

    // Asynchronous reset mid-frame, in the middle of a write cycle
    rst_n = 1'b0;
    #1;
    chk("arst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("arst_addr", 32'(bus.wr_addr), 32'd0);
    chk("arst_data", 32'(bus.wr_data), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_rel_in_ready", 32'(bus.in_ready), 32'd1);
    wq.delete();
    for (int i = 0; i < 6; i++) send(junk[i]);
    idle(1);
    chk("arst_no_hdr_writes", 32'(wq.size()), 32'd0);
    chk("arst_no_hdr_busy", 32'(bus.busy), 32'd0);
    send(8'hA5);
    send(8'h0E);
    send(8'hEE);
    bus.in_valid = 1'b0;
    chk("arst_new_wr_en", 32'(bus.wr_en), 32'd1);
    chk("arst_new_addr", 32'(bus.wr_addr), 32'd0);
    chk("arst_new_data", 32'(bus.wr_data), 32'hEEE);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
